// File: rtl/dab_mod_sequencer.sv
// Purpose : sequences t1/t2/phi/fs/deadtime and the sync run enable for the DAB modulator,
//           with soft start/stop, per-period slew limiting, fault shutdown and a trigger watchdog.
// Latency : parameter steps land on the clk edge after the trigger-edge cycle; rej is a registered
//           one-cycle pulse following the offending cycle. Backpressure: none (strobe/level inputs).
// Ports   : clk/rst (sync, active-high); en run level; load strobe with *_tgt targets; trigger from
//           the modulator; fault level and clear strobe; applied t1_o/t2_o/phi_o/fs_o/dt_o; sync_o;
//           state_o (IDLE=0 ARM=1 RAMP=2 RUN=3 STOP=4 FAULT=5); ramping; rej; fault_o (0/1 ext/2 wd).
module dab_mod_sequencer #(
  parameter int STEP_T    = 4,
  parameter int STEP_PHI  = 2,
  parameter int FS_MIN    = 500,
  parameter int FS_MAX    = 250000,
  parameter int WD_CYCLES = 400000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic signed [8:0]  t1_tgt,
  input  logic signed [8:0]  t2_tgt,
  input  logic signed [8:0]  phi_tgt,
  input  logic signed [18:0] fs_tgt,
  input  logic        [7:0]  dt_tgt,
  input  logic               trigger,
  input  logic               fault,
  input  logic               clear,
  output logic signed [8:0]  t1_o,
  output logic signed [8:0]  t2_o,
  output logic signed [8:0]  phi_o,
  output logic signed [18:0] fs_o,
  output logic        [7:0]  dt_o,
  output logic               sync_o,
  output logic        [2:0]  state_o,
  output logic               ramping,
  output logic               rej,
  output logic        [1:0]  fault_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_RAMP  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_EXT  = 2'd1;
  localparam logic [1:0] F_WD   = 2'd2;

  localparam logic signed [9:0]  STEP_T_V   = 10'(STEP_T);
  localparam logic signed [9:0]  STEP_PHI_V = 10'(STEP_PHI);
  localparam logic signed [18:0] FS_MIN_V   = 19'(FS_MIN);
  localparam logic signed [18:0] FS_MAX_V   = 19'(FS_MAX);
  localparam logic        [19:0] WD_LAST    = 20'(WD_CYCLES - 1);

  // Registered state
  logic [2:0]         state_q,   state_d;
  logic               trig_q,    trig_d;
  logic               en_rej_q,  en_rej_d;
  logic               rej_q,     rej_d;
  logic [1:0]         fault_q,   fault_d;
  logic [19:0]        wd_q,      wd_d;
  logic signed [8:0]  t1_q,      t1_d;
  logic signed [8:0]  t2_q,      t2_d;
  logic signed [8:0]  phi_q,     phi_d;
  logic signed [18:0] fs_q,      fs_d;
  logic [7:0]         dt_q,      dt_d;
  logic signed [8:0]  t1_goal_q, t1_goal_d;
  logic signed [8:0]  t2_goal_q, t2_goal_d;
  logic signed [8:0]  phi_goal_q, phi_goal_d;
  logic signed [18:0] fs_reg_q,  fs_reg_d;
  logic [7:0]         dt_reg_q,  dt_reg_d;

  // Decoded conditions
  logic               tick, active, wd_hit, halt, fs_ok, fs_bad;
  logic signed [8:0]  t1c, t2c, phi_hi, phi_c;
  logic signed [10:0] lim;
  logic [7:0]         dt_c;
  logic               load_idle, load_run, fd_diff, tp_diff;
  logic signed [8:0]  t1_aim, t2_aim, phi_aim;
  logic signed [8:0]  t1_st, t2_st, phi_st;
  logic               at_aim;

  // Move cur toward goal by at most stp.
  function automatic logic signed [8:0] step_to(
    input logic signed [8:0] cur,
    input logic signed [8:0] goal,
    input logic signed [9:0] stp
  );
    logic signed [9:0] d;
    logic signed [9:0] mag;
    d   = {goal[8], goal} - {cur[8], cur};
    mag = d[9] ? -d : d;
    if (mag <= stp)  step_to = goal;
    else if (d[9])   step_to = cur - stp[8:0];
    else             step_to = cur + stp[8:0];
  endfunction

  always_comb begin : cond_p
    tick   = trigger & ~trig_q;
    active = (state_q == S_ARM) || (state_q == S_RAMP) ||
             (state_q == S_RUN) || (state_q == S_STOP);
    wd_hit = active && !tick && (wd_q == WD_LAST);
    halt   = fault | wd_hit;
    fs_ok  = (fs_reg_q >= FS_MIN_V) && (fs_reg_q <= FS_MAX_V);
    fs_bad = (state_q == S_IDLE) && !halt && en && !fs_ok;

    // Target clamping: phi upper bound tracks the t1/t2 duty headroom.
    t1c    = t1_tgt[8] ? 9'sd0 : t1_tgt;
    t2c    = t2_tgt[8] ? 9'sd0 : t2_tgt;
    lim    = {2'b00, t2c} - {2'b00, t1c} + 11'd255;
    phi_hi = (lim > 11'sd255) ? 9'sd255 : lim[8:0];
    if (phi_tgt < -9'sd255)      phi_c = -9'sd255;
    else if (phi_tgt > phi_hi)   phi_c = phi_hi;
    else                         phi_c = phi_tgt;
    dt_c   = (dt_tgt == 8'd0) ? 8'd1 : dt_tgt;

    load_idle = load && (state_q == S_IDLE) && !halt;
    load_run  = load && ((state_q == S_RAMP) || (state_q == S_RUN)) && !halt;
    fd_diff   = (fs_tgt != fs_q) || (dt_c != dt_q);
    tp_diff   = (t1c != t1_q) || (t2c != t2_q) || (phi_c != phi_q);

    // STOP heads for zero, everything else heads for the stored targets.
    t1_aim  = (state_q == S_STOP) ? 9'sd0 : t1_goal_q;
    t2_aim  = (state_q == S_STOP) ? 9'sd0 : t2_goal_q;
    phi_aim = (state_q == S_STOP) ? 9'sd0 : phi_goal_q;
    t1_st   = tick ? step_to(t1_q,  t1_aim,  STEP_T_V)   : t1_q;
    t2_st   = tick ? step_to(t2_q,  t2_aim,  STEP_T_V)   : t2_q;
    phi_st  = tick ? step_to(phi_q, phi_aim, STEP_PHI_V) : phi_q;
    at_aim  = (t1_st == t1_aim) && (t2_st == t2_aim) && (phi_st == phi_aim);
  end

  always_ff @(posedge clk) begin : state_reg_p
    if (rst) begin
      state_q    <= S_IDLE;
      trig_q     <= 1'b0;
      en_rej_q   <= 1'b0;
      rej_q      <= 1'b0;
      fault_q    <= F_NONE;
      wd_q       <= '0;
      t1_q       <= '0;
      t2_q       <= '0;
      phi_q      <= '0;
      fs_q       <= FS_MIN_V;
      dt_q       <= 8'd1;
      t1_goal_q  <= '0;
      t2_goal_q  <= '0;
      phi_goal_q <= '0;
      fs_reg_q   <= '0;
      dt_reg_q   <= '0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      en_rej_q   <= en_rej_d;
      rej_q      <= rej_d;
      fault_q    <= fault_d;
      wd_q       <= wd_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      phi_q      <= phi_d;
      fs_q       <= fs_d;
      dt_q       <= dt_d;
      t1_goal_q  <= t1_goal_d;
      t2_goal_q  <= t2_goal_d;
      phi_goal_q <= phi_goal_d;
      fs_reg_q   <= fs_reg_d;
      dt_reg_q   <= dt_reg_d;
    end
  end

  always_comb begin : next_state_p
    state_d = state_q;
    if (halt) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE:  if (en && fs_ok) state_d = S_ARM;
        S_ARM:   if (!en) state_d = S_STOP;
                 else if (tick) state_d = S_RAMP;
        // A load in the arrival cycle may move the goals, so defer RUN by a cycle.
        S_RAMP:  if (!en) state_d = S_STOP;
                 else if (!load && at_aim) state_d = S_RUN;
        S_RUN:   if (!en) state_d = S_STOP;
                 else if (load && tp_diff) state_d = S_RAMP;
        S_STOP:  if (en) state_d = S_RAMP;
                 else if (at_aim) state_d = S_IDLE;
        S_FAULT: if (clear) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin : datapath_p
    trig_d     = trigger;
    rej_d      = 1'b0;
    t1_d       = t1_q;
    t2_d       = t2_q;
    phi_d      = phi_q;
    fs_d       = fs_q;
    dt_d       = dt_q;
    t1_goal_d  = t1_goal_q;
    t2_goal_d  = t2_goal_q;
    phi_goal_d = phi_goal_q;
    fs_reg_d   = fs_reg_q;
    dt_reg_d   = dt_reg_q;

    // Applied modulation values: hard zero outside the sequenced states.
    if (state_d == S_FAULT || state_q == S_IDLE || state_q == S_FAULT) begin
      t1_d  = '0;
      t2_d  = '0;
      phi_d = '0;
    end else if (state_q == S_RAMP || state_q == S_STOP) begin
      t1_d  = t1_st;
      t2_d  = t2_st;
      phi_d = phi_st;
    end

    // Frequency and deadtime only change on the way out of IDLE.
    if (state_q == S_IDLE && state_d == S_ARM) begin
      fs_d = fs_reg_q;
      dt_d = dt_reg_q;
    end

    if (load_idle || load_run) begin
      t1_goal_d  = t1c;
      t2_goal_d  = t2c;
      phi_goal_d = phi_c;
    end
    if (load_idle) begin
      fs_reg_d = fs_tgt;
      dt_reg_d = dt_c;
    end
    if (load_run && fd_diff) rej_d = 1'b1;
    if (load && !load_idle && !load_run) rej_d = 1'b1;

    // One rejection per en assertion while the stored frequency is unusable.
    if (fs_bad && !en_rej_q) rej_d = 1'b1;
    en_rej_d = en ? (en_rej_q | fs_bad) : 1'b0;

    if (!active || tick || state_d == S_FAULT) wd_d = '0;
    else                                        wd_d = wd_q + 20'd1;

    fault_d = fault_q;
    if (fault)                            fault_d = F_EXT;
    else if (wd_hit)                      fault_d = F_WD;
    else if (state_q == S_FAULT && clear) fault_d = F_NONE;
  end

  always_comb begin : output_p
    sync_o  = (state_q == S_ARM) || (state_q == S_RAMP) ||
              (state_q == S_RUN) || (state_q == S_STOP);
    ramping = (state_q == S_RAMP) || (state_q == S_STOP);
    state_o = state_q;
    t1_o    = t1_q;
    t2_o    = t2_q;
    phi_o   = phi_q;
    fs_o    = fs_q;
    dt_o    = dt_q;
    rej     = rej_q;
    fault_o = fault_q;
  end

endmodule

// File: doc/dab_mod_sequencer.md
Name: dab_mod_sequencer

Overview:
- Sequences the modulation parameters (t1, t2, phi, fs_DAB, deadtime) and the sync run signal fed to the DAB modulator top.
- Provides soft-start, soft-stop and slew-limited parameter changes, stepping at most once per switching period on the modulator's trigger.
- Adds fault shutdown and a trigger watchdog.
- Sits between the host/register interface and the modulator top.

Parameters:
- STEP_T, 4: max change of t1/t2 per switching period (LSB of 0..255 scale).
- STEP_PHI, 2: max change of phi per switching period.
- FS_MIN, 500: minimum accepted fs_DAB in Hz.
- FS_MAX, 250000: maximum accepted fs_DAB in Hz.
- WD_CYCLES, 400000: clk cycles without a trigger edge before a watchdog fault (20-bit counter).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  run request level.
- load  in  1  one-cycle strobe; captures the *_tgt inputs.
- t1_tgt  in  9 signed  target t1, 0..255.
- t2_tgt  in  9 signed  target t2, 0..255.
- phi_tgt  in  9 signed  target phi, -255..255.
- fs_tgt  in  19 signed  target switching frequency in Hz.
- dt_tgt  in  8  target deadtime in clk cycles.
- trigger  in  1  period-start signal from the modulator; may be a pulse or a level.
- fault  in  1  external hard fault, level.
- clear  in  1  fault acknowledge strobe.
- t1_o, t2_o, phi_o  out  9 signed  applied modulation values.
- fs_o  out  19 signed  applied frequency.
- dt_o  out  8  applied deadtime.
- sync_o  out  1  modulator run enable.
- state_o  out  3  FSM state code.
- ramping  out  1  high while in RAMP or STOP.
- rej  out  1  one-cycle pulse when a load or start request is rejected.
- fault_o  out  2  fault cause: 0 none, 1 external, 2 watchdog.

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0, except dt_o = 1 and fs_o = FS_MIN.
  - Target registers cleared; watchdog cleared.
- Trigger edge detection:
  - trig_q <= trigger; tick = trigger & ~trig_q.
  - Parameter steps take effect on the clk edge after the tick cycle (1-cycle latency).
- Target capture on load:
  - t1/t2 are clamped to 0..255.
  - lim = t2c - t1c + 255, computed 11-bit signed.
  - phi is clamped to [-255, min(lim, 255)].
  - fs_tgt and dt_tgt are captured only in IDLE. dt_tgt = 0 is stored as 1.
  - In RAMP/RUN, load captures t1/t2/phi only. If fs_tgt or dt_tgt differs from the applied value, rej pulses and those fields are ignored.
  - load in ARM, STOP or FAULT: ignored, rej pulses.
- Step rule, applied per tick to each of t1/t2/phi:
  - d = goal - cur, 10-bit signed.
  - If |d| <= STEP, cur = goal; else cur = cur ± STEP.
  - All three fields step in the same cycle.
- FSM encoding: IDLE=0, ARM=1, RAMP=2, RUN=3, STOP=4, FAULT=5.
  - IDLE:
    - sync_o = 0; t1/t2/phi = 0.
    - en=1 with FS_MIN <= fs_reg <= FS_MAX → ARM, and fs_o/dt_o are loaded.
    - en=1 with fs_reg out of range → rej pulse, stay in IDLE (one pulse per en rising edge).
  - ARM: sync_o = 1; first tick → RAMP (no step applied on that tick).
  - RAMP:
    - Step toward the targets on each tick.
    - When all three fields equal their targets → RUN.
    - en=0 → STOP.
  - RUN:
    - Hold values.
    - load with any t1/t2/phi difference → RAMP.
    - en=0 → STOP.
  - STOP:
    - Step toward 0 on each tick.
    - When all three fields are zero → IDLE, and sync_o drops in the same cycle.
    - en=1 again → RAMP.
- Priority order: rst > fault/watchdog > en=0 > load.
  - load and en=0 in the same cycle: the load is captured, the state becomes STOP.
- Watchdog:
  - The counter runs in ARM/RAMP/RUN/STOP and clears on each tick.
  - Reaching WD_CYCLES → FAULT with fault_o = 2.
- FAULT:
  - fault=1 in any state → FAULT on the next edge with fault_o = 1.
  - In FAULT: sync_o = 0, t1/t2/phi = 0 immediately (no ramp). fs_o/dt_o hold their values.
  - Exit to IDLE on clear=1 while fault=0. fault_o returns to 0 and targets are kept.
  - clear while fault=1: no effect.
- Reset mid-ramp: immediate return to reset values; there is no soft stop.

Test Plan:
1. Soft start: load t1=223, t2=128, phi=64, fs=100000, dt=20; en=1; trigger every 1000 clk. Required: sync_o rises 1 clk after en; t1_o reads 4, 8, … and reaches 223 after 56 ticks; phi_o reaches 64 after 32 ticks; state becomes RUN after 56 ticks.
2. Phi saturation: t1=223, t2=128, phi=255. Required: phi target = 160, and phi_o settles at 160.
3. Retarget in RUN: load phi=-64. Required: state becomes RAMP; phi_o steps down by 2 per tick to -64, then state returns to RUN. A load in the same sequence with dt=30 produces a rej pulse and dt_o stays 20.
4. Soft stop: en=0 in RUN. Required: all three fields ramp to 0, state becomes IDLE and sync_o=0 on the cycle the last field hits 0.
5. Faults: fault=1 mid-RAMP → next cycle state=5, fault_o=1, sync_o=0, t1/t2/phi=0; clear while fault=1 has no effect; fault=0 then clear → IDLE. Triggers stopped in RUN → fault_o=2 after exactly WD_CYCLES clk.
6. Invalid fs: fs=100 with en=1 → one rej pulse and state stays IDLE. Separately, rst asserted mid-ramp → all outputs at reset values on the next edge.
